// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the instruction-fetch path.
package riscv_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH    = 32;
  localparam int PC_INCR     = 4;

  // One buffered fetch result: the instruction word and the PC it came from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with a single-cycle flush. Push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // Pointer and occupancy bookkeeping; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage is cleared on reset so an empty FIFO presents zeros downstream.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

endmodule

// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer: decoupled prefetch queue between instruction memory and
// decode. Issues sequential fetches, tags each with its PC, buffers results and
// drops in-flight responses after an execute-stage redirect.
// Optional: define FETCH_BUF_BYPASS_EN to forward a response straight to the
// decode outputs when the queue is empty (zero-cycle response-to-valid).
module riscv_fetch_buffer
  import riscv_pkg::*;
#(
  parameter int                       MP_DATA_WIDTH = INSTR_WIDTH,
  parameter int                       MP_ADDR_WIDTH = PC_WIDTH,
  parameter int                       MP_DEPTH      = 4,
  parameter logic [MP_ADDR_WIDTH-1:0] MP_RESET_PC   = '0
) (
  input  logic                     iclk,
  input  logic                     irst,
  output logic                     oimem_req_valid,
  output logic [MP_ADDR_WIDTH-1:0] oimem_req_addr,
  input  logic                     iimem_req_ready,
  input  logic                     iimem_rsp_valid,
  input  logic [MP_DATA_WIDTH-1:0] iimem_rsp_data,
  output logic                     oinstr_valid,
  output logic [MP_DATA_WIDTH-1:0] oinstr,
  output logic [MP_ADDR_WIDTH-1:0] opc,
  input  logic                     iinstr_ready,
  input  logic                     iredirect,
  input  logic [MP_ADDR_WIDTH-1:0] iredirect_pc
);

  localparam int CW = $clog2(MP_DEPTH) + 1;
  localparam int IW = CW + 1;
  localparam int EW = MP_DATA_WIDTH + MP_ADDR_WIDTH;

  logic [MP_ADDR_WIDTH-1:0] fetchPc;
  logic [MP_ADDR_WIDTH-1:0] rspPc;
  logic [CW-1:0]            staleCnt;
  logic [CW-1:0]            qCount;
  logic [CW-1:0]            tagCount;
  logic [IW-1:0]            inFlight;
  logic [EW-1:0]            qHead;
  logic                     qEmpty;
  logic                     qFull;
  logic                     tagFull;
  logic                     tagEmpty;
  logic                     reqFire;
  logic                     rspLive;
  logic                     qPush;
  logic                     qPop;
  logic                     unusedFlags;

  // The tag FIFO count doubles as the outstanding-request counter.
  assign inFlight        = IW'(qCount) + IW'(tagCount);
  assign oimem_req_valid = irst && !iredirect && (inFlight < IW'(MP_DEPTH));
  assign oimem_req_addr  = fetchPc;
  assign reqFire         = oimem_req_valid && iimem_req_ready;
  assign rspLive         = iimem_rsp_valid && !iredirect && (staleCnt == '0);
  assign qPop            = !qEmpty && iinstr_ready && !iredirect;
  assign unusedFlags     = qFull ^ tagFull ^ tagEmpty;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypassHit;
  assign bypassHit    = rspLive && qEmpty;
  assign qPush        = rspLive && !(bypassHit && iinstr_ready);
  assign oinstr_valid = !qEmpty || bypassHit;
  assign oinstr       = bypassHit ? iimem_rsp_data : qHead[EW-1 -: MP_DATA_WIDTH];
  assign opc          = bypassHit ? rspPc : qHead[MP_ADDR_WIDTH-1:0];
`else
  assign qPush        = rspLive;
  assign oinstr_valid = !qEmpty;
  assign oinstr       = qHead[EW-1 -: MP_DATA_WIDTH];
  assign opc          = qHead[MP_ADDR_WIDTH-1:0];
`endif

  fetch_fifo #(
    .WIDTH (MP_ADDR_WIDTH),
    .DEPTH (MP_DEPTH)
  ) uTagFifo (
    .clk      (iclk),
    .rstN     (irst),
    .flush    (1'b0),
    .push     (reqFire),
    .pushData (fetchPc),
    .pop      (iimem_rsp_valid),
    .popData  (rspPc),
    .full     (tagFull),
    .empty    (tagEmpty),
    .count    (tagCount)
  );

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (MP_DEPTH)
  ) uEntryQueue (
    .clk      (iclk),
    .rstN     (irst),
    .flush    (iredirect),
    .push     (qPush),
    .pushData ({iimem_rsp_data, rspPc}),
    .pop      (qPop),
    .popData  (qHead),
    .full     (qFull),
    .empty    (qEmpty),
    .count    (qCount)
  );

  // Fetch PC: a redirect target wins, otherwise step past each accepted request.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      fetchPc <= MP_RESET_PC;
    end else if (iredirect) begin
      fetchPc <= iredirect_pc;
    end else if (reqFire) begin
      fetchPc <= fetchPc + MP_ADDR_WIDTH'(PC_INCR);
    end
  end

  // Stale counter: on redirect every request still in flight (except one
  // returning this very cycle, dropped already) becomes a response to discard.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      staleCnt <= '0;
    end else if (iredirect) begin
      staleCnt <= tagCount - CW'(iimem_rsp_valid);
    end else if (iimem_rsp_valid && (staleCnt != '0)) begin
      staleCnt <= staleCnt - CW'(1);
    end
  end

endmodule

// File: doc/riscv_fetch_buffer.md
# riscv_fetch_buffer

Parametrised instruction-fetch front end that replaces the bare PC-to-instruction-memory path of the pipelined core with a decoupled prefetch queue. Issues sequential fetch requests over a valid/ready handshake and tolerates variable memory latency. Buffers up to MP_DEPTH instructions with their PCs and flushes cleanly on an execute-stage redirect. Sits between the instruction memory and the decode pipeline register, and drives the F-stage stall that was previously fixed-latency.

## Interface
- MP_DATA_WIDTH, 32, instruction word width
- MP_ADDR_WIDTH, 32, PC / fetch address width
- MP_DEPTH, 4, queue entries; power of two, ≥2
- MP_RESET_PC, 0, first fetch address after reset
- iclk  in  1  clock, rising edge
- irst  in  1  reset, asynchronous, active-low
- oimem_req_valid  out  1  fetch request valid
- oimem_req_addr  out  MP_ADDR_WIDTH  fetch address
- iimem_req_ready  in  1  memory accepts request
- iimem_rsp_valid  in  1  response valid; in order, no backpressure
- iimem_rsp_data  in  MP_DATA_WIDTH  fetched instruction
- oinstr_valid  out  1  head entry valid
- oinstr  out  MP_DATA_WIDTH  head instruction
- opc  out  MP_ADDR_WIDTH  PC of head instruction
- iinstr_ready  in  1  decode accepts head (low = StallD)
- iredirect  in  1  taken branch/jump from E stage (PCSrcE)
- iredirect_pc  in  MP_ADDR_WIDTH  redirect target

## Operation
- State: fetch PC register, queue (instr+PC per entry), outstanding counter, stale counter; counters $clog2(MP_DEPTH)+1 bits.
- Request: oimem_req_valid = !iredirect && (occupancy + outstanding < MP_DEPTH). Address = fetch PC. On valid&ready: outstanding+1, fetch PC += 4 (wraps modulo 2^MP_ADDR_WIDTH).
- Request PC is pushed onto an internal in-order PC tag FIFO (depth MP_DEPTH) and popped with each response.
- Response: if stale counter > 0, discard, stale−1; else push {data, tagged PC} into queue. Either way outstanding−1.
- Pop: oinstr_valid && iinstr_ready removes head. Simultaneous push and pop on a full queue is legal.
- Redirect (priority over everything): queue emptied; stale ← outstanding minus any response arriving this cycle, plus nothing for requests (none issued in redirect cycle); fetch PC ← iredirect_pc; pop that cycle ignored.
- Misaligned iredirect_pc is passed through unchanged; alignment checking is out of scope.
- Occupancy + outstanding never exceeds MP_DEPTH, so a response always has a free slot.

## Timing
- Reset values: oimem_req_valid 0, oimem_req_addr MP_RESET_PC, oinstr_valid 0, oinstr 0, opc 0, all counters 0.
- First cycle after irst deasserts: oimem_req_valid=1, addr=MP_RESET_PC.
- Response-to-oinstr_valid latency: 1 cycle (registered queue).
- Redirect in cycle N: oinstr_valid=0 in N+1; request for iredirect_pc presented in N+1.
- Redirect concurrent with response: that response discarded, not counted as stale.
- Back-to-back redirects: each re-latches stale from current outstanding; last target wins.
- Reset mid-operation clears all state and forgets outstanding requests; instruction memory shares the reset.
- Full throughput: one instruction per cycle with zero-wait memory and iinstr_ready high.

## Configuration
- FETCH_BUF_BYPASS_EN defined: when queue empty, response non-stale, no redirect, the response drives oinstr/opc/oinstr_valid combinationally the same cycle; if iinstr_ready also high the entry is not written. Response-to-valid latency 0.
- Undefined: all responses go through the queue; latency 1; outputs purely registered.

## Structure
- Shared package riscv_pkg: instruction width, PC increment constant (4), fetch-entry struct {instr, pc}.
- One sub-module: fetch_fifo — synchronous FIFO with flush input, parametrised width/depth, full/empty/count outputs; instantiated twice (entry queue, PC tag FIFO).

## Test plan
- Reset, zero-wait memory, ready high → addrs 0x0,0x4,0x8… issued each cycle; opc sequence matches, one instr/cycle after 1-cycle fill.
- iinstr_ready held low 10 cycles, MP_DEPTH=4 → exactly 4 requests accepted, oimem_req_valid low afterward, no data lost, order preserved on release.
- 3-cycle memory latency, 3 outstanding, redirect to 0x100 → 3 stale responses dropped, next oinstr has opc=0x100.
- Redirect in same cycle as response and as consumer pop → response dropped, queue empty next cycle, request 0x100 issued next cycle.
- irst asserted with 2 outstanding and 2 queued → all outputs reset values immediately; after release first request at MP_RESET_PC.
- With FETCH_BUF_BYPASS_EN, empty queue, response 0x00500093 at PC 0x8 → oinstr_valid, oinstr=0x00500093, opc=0x8 same cycle; without macro, one cycle later.
